base_rrmux: RTL and testbench

//  Round-robin arbiter + mux with packet lock and one registered output stage.

---
 rtl/base_pkg.sv | 25 ++
 rtl/base_mux.sv | 21 ++
 rtl/base_rrarb.sv | 41 ++++
 rtl/base_rrmux.sv | 181 ++++++++++++++++++
 tb/tb_base_rrmux.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/base_pkg.sv
// Shared constants, lock-state type and width helpers for base_rrmux.
// Holds the perf counter width and the pointer/index width function.
package base_pkg;

   localparam int BASE_RRMUX_CNT_W = 16;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } lock_st_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   // pointer / lock_way width, at least one bit
   function automatic int ptr_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/base_mux.sv
// Indexed data select from a packed per-way bus (way 0 in the msbs).
// Ports: i_d (ways*width), i_sel (index) -> o_d (width).
module base_mux
   import base_pkg::*;
#(
   parameter int ways  = 2,
   parameter int width = 1,
   parameter int pw    = 1
) (
   input  logic [ways*width-1:0] i_d,
   input  logic [pw-1:0]         i_sel,
   output logic [width-1:0]      o_d
);

   always_comb begin
      o_d = '0;
      for (int w = 0; w < ways; w++)
         if (i_sel == pw'(w)) o_d = i_d[(ways-1-w)*width +: width];
   end

endmodule

// File: rtl/base_rrarb.sv
// Rotating-priority picker: first valid way scanning ptr, ptr+1 .. wrap.
// Ports: i_v (bit w = way w), i_ptr -> o_gnt one-hot, o_idx, o_any.
module base_rrarb
   import base_pkg::*;
#(
   parameter int ways = 2,
   parameter int pw   = 1
) (
   input  logic [ways-1:0] i_v,
   input  logic [pw-1:0]   i_ptr,
   output logic [ways-1:0] o_gnt,
   output logic [pw-1:0]   o_idx,
   output logic            o_any
);

   localparam int SW = pw + 1;

   logic [SW-1:0] w_s;
   logic [pw-1:0] w_j;

   // scan from farthest to nearest so the nearest valid way wins
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_s   = '0;
      w_j   = '0;
      for (int k = ways - 1; k >= 0; k--) begin
         w_s = {1'b0, i_ptr} + SW'(k);
         if (w_s >= SW'(ways)) w_s = w_s - SW'(ways);
         w_j = w_s[pw-1:0];
         if (i_v[w_j]) begin
            o_gnt      = '0;
            o_gnt[w_j] = 1'b1;
            o_idx      = w_j;
            o_any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/base_rrmux.sv
// Round-robin arbiter + mux with packet lock and one registered output stage.
// Ports: clk, reset (async high); i_v/i_d/i_e/i_r per way (way 0 in msbs);
//        o_v/o_d/o_e/o_sel registered out, o_r downstream ready.
// BASE_RRMUX_PERF_EN adds o_pkt_cnt: saturating 16-bit packet count per way.
module base_rrmux
   import base_pkg::*;
#(
   parameter int ways  = 2,
   parameter int width = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ways-1:0]        i_v,
   input  logic [ways*width-1:0]  i_d,
   input  logic [ways-1:0]        i_e,
   output logic [ways-1:0]        i_r,
   output logic                   o_v,
   output logic [width-1:0]       o_d,
   output logic                   o_e,
   input  logic                   o_r,
   output logic [ways-1:0]        o_sel
`ifdef BASE_RRMUX_PERF_EN
   ,
   output logic [ways*BASE_RRMUX_CNT_W-1:0] o_pkt_cnt
`endif
);

   localparam int PW = ptr_w(ways);

   logic             r_v;
   logic [width-1:0] r_d;
   logic             r_e;
   logic [ways-1:0]  r_sel;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_lock_way;
   lock_st_t         r_state;

   logic [ways-1:0]  w_vn;
   logic [ways-1:0]  w_en;
   logic [ways-1:0]  w_agnt;
   logic [PW-1:0]    w_aidx;
   logic             w_aany;
   logic [ways-1:0]  w_gnt;
   logic [PW-1:0]    w_idx;
   logic             w_any;
   logic             w_ld;
   logic             w_xfer;
   logic             w_end;
   logic [PW-1:0]    w_nptr;
   logic [width-1:0] w_d;
   logic [ways-1:0]  w_selp;
   logic [ways-1:0]  w_rp;

   // internal vectors use bit w = way w
   always_comb begin
      w_vn = '0;
      w_en = '0;
      for (int w = 0; w < ways; w++) begin
         w_vn[w] = i_v[ways-1-w];
         w_en[w] = i_e[ways-1-w];
      end
   end

   base_rrarb #(
      .ways (ways),
      .pw   (PW)
   ) u_arb (
      .i_v   (w_vn),
      .i_ptr (r_ptr),
      .o_gnt (w_agnt),
      .o_idx (w_aidx),
      .o_any (w_aany)
   );

   // a locked packet owns the channel even while its way is idle
   always_comb begin
      w_gnt = '0;
      w_idx = w_aidx;
      w_any = w_aany;
      if (r_state == ST_LOCKED) begin
         w_gnt[r_lock_way] = w_vn[r_lock_way];
         w_idx             = r_lock_way;
         w_any             = w_vn[r_lock_way];
      end else begin
         w_gnt = w_agnt;
      end
   end

   assign w_ld   = ~r_v | o_r;
   assign w_xfer = w_ld & w_any;
   assign w_end  = w_en[w_idx];
   assign w_nptr = (w_idx == PW'(ways - 1)) ? '0 : w_idx + PW'(1);

   always_comb begin
      w_rp   = '0;
      w_selp = '0;
      for (int w = 0; w < ways; w++) begin
         w_rp[ways-1-w]   = w_ld & w_gnt[w];
         w_selp[ways-1-w] = w_gnt[w];
      end
   end

   base_mux #(
      .ways  (ways),
      .width (width),
      .pw    (PW)
   ) u_mux (
      .i_d   (i_d),
      .i_sel (w_idx),
      .o_d   (w_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v        <= 1'b0;
         r_d        <= '0;
         r_e        <= 1'b0;
         r_sel      <= '0;
         r_ptr      <= '0;
         r_lock_way <= '0;
         r_state    <= ST_IDLE;
      end else begin
         if (w_ld) begin
            r_v <= w_any;
            if (w_any) begin
               r_d   <= w_d;
               r_e   <= w_end;
               r_sel <= w_selp;
            end
         end
         // pointer moves per packet, on its end beat only
         if (w_xfer && w_end) r_ptr <= w_nptr;
         unique case (r_state)
            ST_IDLE: begin
               if (w_xfer && !w_end) begin
                  r_state    <= ST_LOCKED;
                  r_lock_way <= w_idx;
               end
            end
            ST_LOCKED: begin
               if (w_xfer && w_end) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign i_r   = w_rp;
   assign o_v   = r_v;
   assign o_d   = r_d;
   assign o_e   = r_e;
   assign o_sel = r_sel;

`ifdef BASE_RRMUX_PERF_EN
   logic [BASE_RRMUX_CNT_W-1:0] r_cnt [ways];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < ways; w++) r_cnt[w] <= '0;
      end else begin
         for (int w = 0; w < ways; w++)
            if (w_xfer && w_end && w_gnt[w] && (r_cnt[w] != '1))
               r_cnt[w] <= r_cnt[w] + BASE_RRMUX_CNT_W'(1);
      end
   end

   always_comb begin
      o_pkt_cnt = '0;
      for (int w = 0; w < ways; w++)
         o_pkt_cnt[(ways-1-w)*BASE_RRMUX_CNT_W +: BASE_RRMUX_CNT_W] = r_cnt[w];
   end
`endif

   // upstream must hold a pending beat unchanged until it is accepted
   for (genvar g = 0; g < ways; g++) begin : g_hold
      a_hold: assert property (@(posedge clk) disable iff (reset)
         (i_v[g] && !i_r[g]) |=>
         (i_v[g] && $stable(i_e[g]) && $stable(i_d[g*width +: width])));
   end

endmodule

// File: tb/tb_base_rrmux.sv
// Directed bench for base_rrmux: rotation, packet lock, stalls, async reset.
// With BASE_RRMUX_PERF_EN a 2-way instance also checks counter saturation.
module tb_base_rrmux;

   logic        clk;
   logic        reset;
   logic [3:0]  i_v;
   logic [31:0] i_d;
   logic [3:0]  i_e;
   logic [3:0]  i_r;
   logic        o_v;
   logic [7:0]  o_d;
   logic        o_e;
   logic        o_r;
   logic [3:0]  o_sel;

   int n_chk;
   int n_fail;

`ifdef BASE_RRMUX_PERF_EN
   logic [63:0] pc4;
   logic [1:0]  p_v;
   logic [15:0] p_d;
   logic [1:0]  p_e;
   logic [1:0]  p_r;
   logic        p_ov;
   logic [7:0]  p_od;
   logic        p_oe;
   logic        p_or;
   logic [1:0]  p_sel;
   logic [31:0] p_cnt;

   base_rrmux #(.ways(2), .width(8)) u_perf (
      .clk       (clk),
      .reset     (reset),
      .i_v       (p_v),
      .i_d       (p_d),
      .i_e       (p_e),
      .i_r       (p_r),
      .o_v       (p_ov),
      .o_d       (p_od),
      .o_e       (p_oe),
      .o_r       (p_or),
      .o_sel     (p_sel),
      .o_pkt_cnt (p_cnt)
   );
`endif

   base_rrmux #(.ways(4), .width(8)) u_dut (
      .clk   (clk),
      .reset (reset),
      .i_v   (i_v),
      .i_d   (i_d),
      .i_e   (i_e),
      .i_r   (i_r),
      .o_v   (o_v),
      .o_d   (o_d),
      .o_e   (o_e),
      .o_r   (o_r),
      .o_sel (o_sel)
`ifdef BASE_RRMUX_PERF_EN
      ,
      .o_pkt_cnt (pc4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst;
      reset = 1'b1;
      #1;
      i_v = '0;
      i_e = '0;
      i_d = '0;
      tick();
      reset = 1'b0;
   endtask

   logic [3:0] exp_sel [5];
   logic [7:0] exp_d   [5];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      i_v    = '0;
      i_d    = '0;
      i_e    = '0;
      o_r    = 1'b1;
`ifdef BASE_RRMUX_PERF_EN
      p_v  = '0;
      p_d  = '0;
      p_e  = '0;
      p_or = 1'b1;
`endif
      tick();
      tick();
      check("rst_ov", o_v, 1'b0);
      check("rst_sel", o_sel, 4'b0000);
      check("rst_od", o_d, 8'h00);
      check("rst_oe", o_e, 1'b0);
      reset = 1'b0;

      // 1: all ways valid, single beats -> rotation
      exp_sel = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
      exp_d   = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
      i_d = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
      i_e = 4'b1111;
      i_v = 4'b1111;
      #1;
      check("t1_ir0", i_r, 4'b1000);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t1_ov", o_v, 1'b1);
         check("t1_sel", o_sel, exp_sel[k]);
         check("t1_od", o_d, exp_d[k]);
      end
      pulse_rst();

      // 2: way1 3-beat packet while way0/2 wait
      i_d = {8'h10, 8'hB0, 8'hC2, 8'h00};
      i_e = 4'b1000;
      i_v = 4'b1000;
      tick();
      check("t2_pre_sel", o_sel, 4'b1000);
      i_v = 4'b1110;
      i_e = 4'b1010;
      #1;
      check("t2_ir_b0", i_r, 4'b0100);
      tick();
      check("t2_sel_b0", o_sel, 4'b0100);
      check("t2_od_b0", o_d, 8'hB0);
      check("t2_oe_b0", o_e, 1'b0);
      i_d = {8'h10, 8'hB1, 8'hC2, 8'h00};
      #1;
      check("t2_ir_b1", i_r, 4'b0100);
      tick();
      check("t2_sel_b1", o_sel, 4'b0100);
      check("t2_od_b1", o_d, 8'hB1);
      i_d = {8'h10, 8'hB2, 8'hC2, 8'h00};
      i_e = 4'b1110;
      tick();
      check("t2_sel_b2", o_sel, 4'b0100);
      check("t2_od_b2", o_d, 8'hB2);
      check("t2_oe_b2", o_e, 1'b1);
      i_v = 4'b1010;
      #1;
      check("t2_ir_next", i_r, 4'b0010);
      tick();
      check("t2_sel_next", o_sel, 4'b0010);
      check("t2_od_next", o_d, 8'hC2);
      pulse_rst();

      // 3: locked way0 goes idle mid-packet, way3 must not fill the gap
      i_d = {8'hD0, 8'h00, 8'h00, 8'hE3};
      i_e = 4'b0001;
      i_v = 4'b1001;
      #1;
      check("t3_ir0", i_r, 4'b1000);
      tick();
      check("t3_sel0", o_sel, 4'b1000);
      check("t3_od0", o_d, 8'hD0);
      check("t3_oe0", o_e, 1'b0);
      i_v = 4'b0001;
      #1;
      check("t3_ir_gap", i_r, 4'b0000);
      tick();
      check("t3_ov_gap1", o_v, 1'b0);
      check("t3_ir_gap1", i_r, 4'b0000);
      tick();
      check("t3_ov_gap2", o_v, 1'b0);
      i_d = {8'hD1, 8'h00, 8'h00, 8'hE3};
      i_e = 4'b1001;
      i_v = 4'b1001;
      #1;
      check("t3_ir_resume", i_r, 4'b1000);
      tick();
      check("t3_ov1", o_v, 1'b1);
      check("t3_sel1", o_sel, 4'b1000);
      check("t3_od1", o_d, 8'hD1);
      check("t3_oe1", o_e, 1'b1);
      i_v = 4'b0001;
      #1;
      check("t3_ir3", i_r, 4'b0001);
      tick();
      check("t3_sel3", o_sel, 4'b0001);
      check("t3_od3", o_d, 8'hE3);
      pulse_rst();

      // 4: downstream stall for 5 clocks
      i_d = {8'hF0, 8'hF1, 8'h00, 8'h00};
      i_e = 4'b1100;
      i_v = 4'b1100;
      tick();
      check("t4_sel0", o_sel, 4'b1000);
      o_r = 1'b0;
      i_v = 4'b0100;
      #1;
      check("t4_ir_stall", i_r, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t4_ov_hold", o_v, 1'b1);
         check("t4_sel_hold", o_sel, 4'b1000);
         check("t4_od_hold", o_d, 8'hF0);
         check("t4_ir_hold", i_r, 4'b0000);
      end
      o_r = 1'b1;
      #1;
      check("t4_ir_go", i_r, 4'b0100);
      tick();
      check("t4_ov1", o_v, 1'b1);
      check("t4_sel1", o_sel, 4'b0100);
      check("t4_od1", o_d, 8'hF1);
      i_v = 4'b0000;
      tick();
      check("t4_ov_end", o_v, 1'b0);
      pulse_rst();

      // 5: async reset in the middle of a locked packet
      i_d = {8'h11, 8'h55, 8'h00, 8'h00};
      i_e = 4'b1000;
      i_v = 4'b1000;
      tick();
      i_v = 4'b0100;
      i_e = 4'b0000;
      #1;
      check("t5_ir1", i_r, 4'b0100);
      tick();
      check("t5_sel1", o_sel, 4'b0100);
      check("t5_od1", o_d, 8'h55);
      i_d = {8'h11, 8'h56, 8'h00, 8'h00};
      #2;
      reset = 1'b1;
      #1;
      check("t5_ov_rst", o_v, 1'b0);
      check("t5_sel_rst", o_sel, 4'b0000);
      i_v = 4'b1100;
      i_e = 4'b1100;
      #1;
      check("t5_ir_rst", i_r, 4'b1000);
      tick();
      reset = 1'b0;
      #1;
      check("t5_ir_post", i_r, 4'b1000);
      tick();
      check("t5_sel_post", o_sel, 4'b1000);
      check("t5_od_post", o_d, 8'h11);
      tick();
      check("t5_sel_way1", o_sel, 4'b0100);
      check("t5_od_way1", o_d, 8'h56);
      pulse_rst();

`ifdef BASE_RRMUX_PERF_EN
      // 6: per-way packet counter saturation
      p_d = 16'h0102;
      p_e = 2'b10;
      p_v = 2'b10;
      #1;
      check("t6_ir", p_r, 2'b10);
      repeat (3) tick();
      check("t6_cnt3", p_cnt, {16'd3, 16'd0});
      check("t6_sel", p_sel, 2'b10);
      repeat (69997) tick();
      check("t6_cnt_sat", p_cnt[31:16], 16'hFFFF);
      check("t6_cnt_w1", p_cnt[15:0], 16'h0000);
      reset = 1'b1;
      #1;
      p_v = '0;
      check("t6_cnt_rst", p_cnt, 32'h0);
      tick();
      reset = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
